// File: rtl/sm_icache.sv
// Direct-mapped read-only instruction cache: single-cycle hits, whole-line refill
// from word-addressed ROM on a miss, whole-cache invalidate and hit/miss counters.
module sm_icache #(
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 2,
  parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ready,
  output logic              cpu_valid,
  output logic [31:0]       cpu_rdata,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [31:0]       mem_rdata,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);

  localparam int WORDS = 1 << OFFSET_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    RESP
  } state_t;

  state_t              state_q, state_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [31:0]         data_q [LINES][WORDS];
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d;
  logic                cpu_valid_q, cpu_valid_d;
  logic [31:0]         cpu_rdata_q, cpu_rdata_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [15:0]         hit_cnt_q, hit_cnt_d;
  logic [15:0]         miss_cnt_q, miss_cnt_d;
  logic                flush_pending_q, flush_pending_d;

  logic [OFFSET_W-1:0] cpu_off, req_off, cnt_inc;
  logic [INDEX_W-1:0]  cpu_idx, req_idx;
  logic [TAG_W-1:0]    cpu_tag, req_tag;
  logic                cpu_hit, fill_beat, last_word;
  logic                fill_we, tag_we;

  assign cpu_off = cpu_addr[OFFSET_W-1:0];
  assign cpu_idx = cpu_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign cpu_tag = cpu_addr[ADDR_W-1:OFFSET_W+INDEX_W];
  assign req_off = req_addr_q[OFFSET_W-1:0];
  assign req_idx = req_addr_q[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign req_tag = req_addr_q[ADDR_W-1:OFFSET_W+INDEX_W];

  assign cpu_hit   = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  assign fill_beat = mem_req_q && mem_valid;
  assign last_word = (cnt_q == OFFSET_W'(WORDS - 1));
  assign cnt_inc   = cnt_q + OFFSET_W'(1);

  assign cpu_ready = (state_q == IDLE) && !flush && !flush_pending_q;
  assign cpu_valid = cpu_valid_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

  always_comb begin
    state_d         = state_q;
    valid_d         = valid_q;
    req_addr_d      = req_addr_q;
    cnt_d           = cnt_q;
    cpu_valid_d     = 1'b0;
    cpu_rdata_d     = cpu_rdata_q;
    mem_req_d       = mem_req_q;
    mem_addr_d      = mem_addr_q;
    hit_cnt_d       = hit_cnt_q;
    miss_cnt_d      = miss_cnt_q;
    flush_pending_d = flush_pending_q;
    fill_we         = 1'b0;
    tag_we          = 1'b0;

    // A flush while busy is deferred so the in-flight refill still completes.
    if (flush && (state_q != IDLE)) begin
      flush_pending_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (flush || flush_pending_q) begin
          valid_d         = '0;
          flush_pending_d = 1'b0;
        end else if (cpu_req) begin
          if (cpu_hit) begin
            cpu_valid_d = 1'b1;
            cpu_rdata_d = data_q[cpu_idx][cpu_off];
            hit_cnt_d   = hit_cnt_q + 16'd1;
          end else begin
            req_addr_d = cpu_addr;
            miss_cnt_d = miss_cnt_q + 16'd1;
            cnt_d      = '0;
            mem_req_d  = 1'b1;
            mem_addr_d = {cpu_tag, cpu_idx, {OFFSET_W{1'b0}}};
            state_d    = REFILL;
          end
        end
      end

      REFILL: begin
        if (fill_beat) begin
          fill_we    = 1'b1;
          cnt_d      = cnt_inc;
          mem_addr_d = {req_tag, req_idx, cnt_inc};
          // The requested word may be arriving right now, so bypass the array.
          if (last_word) begin
            valid_d[req_idx] = 1'b1;
            tag_we           = 1'b1;
            mem_req_d        = 1'b0;
            cpu_valid_d      = 1'b1;
            cpu_rdata_d      = (req_off == cnt_q) ? mem_rdata : data_q[req_idx][req_off];
            state_d          = RESP;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      valid_q         <= '0;
      req_addr_q      <= '0;
      cnt_q           <= '0;
      cpu_valid_q     <= 1'b0;
      cpu_rdata_q     <= '0;
      mem_req_q       <= 1'b0;
      mem_addr_q      <= '0;
      hit_cnt_q       <= '0;
      miss_cnt_q      <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      req_addr_q      <= req_addr_d;
      cnt_q           <= cnt_d;
      cpu_valid_q     <= cpu_valid_d;
      cpu_rdata_q     <= cpu_rdata_d;
      mem_req_q       <= mem_req_d;
      mem_addr_q      <= mem_addr_d;
      hit_cnt_q       <= hit_cnt_d;
      miss_cnt_q      <= miss_cnt_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  // Tag and data storage need no reset; the valid vector guards them.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[req_idx][cnt_q] <= mem_rdata;
    end
    if (tag_we) begin
      tag_q[req_idx] <= req_tag;
    end
  end

endmodule

// File: tb/tb_sm_icache.sv
// Randomized scoreboard bench for sm_icache: a line-residency model predicts hit/miss,
// data and latency; a negedge monitor checks responses and the refill address stream.
module tb_sm_icache;

  localparam int ADDR_W   = 32;
  localparam int INDEX_W  = 4;
  localparam int OFFSET_W = 2;
  localparam int WORDS    = 1 << OFFSET_W;
  localparam int LINES    = 1 << INDEX_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ready;
  logic              cpu_valid;
  logic [31:0]       cpu_rdata;
  logic              flush;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_valid;
  logic [31:0]       mem_rdata;
  logic [15:0]       hit_cnt;
  logic [15:0]       miss_cnt;

  always #5 clk = ~clk;

  sm_icache #(
    .ADDR_W(ADDR_W),
    .INDEX_W(INDEX_W),
    .OFFSET_W(OFFSET_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cpu_req(cpu_req),
    .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready),
    .cpu_valid(cpu_valid),
    .cpu_rdata(cpu_rdata),
    .flush(flush),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_valid(mem_valid),
    .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          lat = 0;
  int          wait_cnt = 0;
  logic        noise = 1'b0;
  int          misses_started = 0;
  int          refills_done = 0;
  int          beats = 0;
  int          last_acc_cyc = 0;
  logic [31:0] refill_base = '0;
  bit          res_v[LINES];
  logic [29:0] res_line[LINES];
  int          model_hits = 0;
  int          model_misses = 0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'hA000_0000 + a;
  endfunction

  // ROM with L wait cycles per word; random mem_valid noise while no request is open.
  assign mem_valid = mem_req ? (wait_cnt >= lat) : noise;
  assign mem_rdata = rom(mem_addr);

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    noise <= 1'($urandom_range(0, 1));
    if (rst || !mem_req || mem_valid) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    if (rst) begin
      beats        <= 0;
      refills_done <= 0;
    end else if (mem_req && mem_valid) begin
      if (beats == WORDS - 1) begin
        beats        <= 0;
        refills_done <= refills_done + 1;
      end else begin
        beats <= beats + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every response and tracks the refill address stream.
  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("rdata", cpu_rdata, e.data);
          checkOutput("latency_cycle", 32'(cyc), 32'(e.due));
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
        checkOutput("missing_valid", 32'(cyc), 32'(exp_q[0].due));
        void'(exp_q.pop_front());
      end
      if (mem_req) begin
        checkOutput("mem_req_allowed", 32'(misses_started != refills_done), 32'd1);
        checkOutput("mem_addr", mem_addr, refill_base + 32'(beats));
      end
    end
  end

  task automatic clearModel();
    for (int i = 0; i < LINES; i++) res_v[i] = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input bit with_flush);
    int   guard;
    logic acc;
    int   idx;
    guard = 0;
    @(negedge clk);
    while (!cpu_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (!cpu_ready) checkOutput("ready_timeout", 32'd0, 32'd1);
    cpu_req  = 1'b1;
    cpu_addr = addr;
    flush    = with_flush;
    #1;
    acc = cpu_ready;
    if (with_flush) begin
      checkOutput("flush_blocks_req", 32'(acc), 32'd0);
      clearModel();
    end else if (acc) begin
      idx = int'(addr[OFFSET_W+INDEX_W-1:OFFSET_W]);
      last_acc_cyc = cyc;
      if (res_v[idx] && res_line[idx] == addr[31:OFFSET_W]) begin
        model_hits++;
        exp_q.push_back('{data: rom(addr), due: cyc + 1});
      end else begin
        model_misses++;
        res_v[idx]    = 1'b1;
        res_line[idx] = addr[31:OFFSET_W];
        refill_base   = addr & ~32'(WORDS - 1);
        misses_started++;
        exp_q.push_back('{data: rom(addr), due: cyc + WORDS * (lat + 1) + 1});
      end
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic pulseFlush();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    clearModel();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic checkCounters();
    checkOutput("hit_cnt", 32'(hit_cnt), 32'(model_hits & 16'hFFFF));
    checkOutput("miss_cnt", 32'(miss_cnt), 32'(model_misses & 16'hFFFF));
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          r;
    int          guard;
    logic [31:0] a;

    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; flush = 1'b0; lat = 0;
    clearModel();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_cpu_valid", 32'(cpu_valid), 32'd0);
    checkOutput("reset_cpu_rdata", cpu_rdata, 32'd0);
    checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset_mem_addr", mem_addr, 32'd0);
    checkOutput("reset_cpu_ready", 32'(cpu_ready), 32'd1);
    checkCounters();

    // Cold miss with zero-wait memory, then ready returns at t+WORDS+2.
    applyStimulus(32'h12, 1'b0);
    guard = 0;
    @(negedge clk);
    while (!cpu_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("ready_after_miss", 32'(cyc - last_acc_cyc), 32'(WORDS + 2));
    drain();
    checkCounters();

    // Hits, back to back.
    applyStimulus(32'h13, 1'b0);
    applyStimulus(32'h10, 1'b0);
    applyStimulus(32'h11, 1'b0);
    drain();
    checkCounters();

    // Conflict eviction on index 4.
    applyStimulus(32'h110, 1'b0);
    applyStimulus(32'h10, 1'b0);
    drain();
    checkCounters();

    // Wait-state memory.
    lat = 2;
    applyStimulus(32'h20, 1'b0);
    drain();
    lat = 0;

    // Flush with a request, then a flush raised mid-refill.
    applyStimulus(32'h12, 1'b1);
    applyStimulus(32'h12, 1'b0);
    drain();
    applyStimulus(32'h30, 1'b0);
    repeat (2) @(negedge clk);
    pulseFlush();
    drain();
    applyStimulus(32'h30, 1'b0);
    drain();
    checkCounters();

    // Reset in cycle 2 of a refill abandons it.
    applyStimulus(32'h44, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    clearModel();
    model_hits = 0;
    model_misses = 0;
    misses_started = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mid_cpu_valid", 32'(cpu_valid), 32'd0);
    checkCounters();
    applyStimulus(32'h44, 1'b0);
    drain();
    checkCounters();

    // Randomized mix of hits, misses, conflicts, flushes and memory latencies.
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      a = (32'($urandom_range(0, 3)) << 30) | (32'($urandom_range(0, 1)) << 6)
          | 32'($urandom_range(0, 63));
      if (r < 6) begin
        drain();
        lat = $urandom_range(0, 3);
        applyStimulus(a, 1'b0);
      end else if (r < 11) begin
        applyStimulus(a, 1'b1);
      end else if (r < 15) begin
        applyStimulus(a, 1'b0);
        repeat ($urandom_range(0, 4)) @(negedge clk);
        pulseFlush();
      end else begin
        applyStimulus(a, 1'b0);
      end
      if (r >= 95) repeat (2) @(negedge clk);
    end
    drain();
    checkCounters();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sm_icache.md
# sm_icache

Direct-mapped, read-only instruction cache between the CPU fetch port and the word-addressed instruction ROM. It serves hits in one cycle. On a miss it refills the whole line by issuing sequential word reads to the backing memory, then delivers the requested word. It also supports whole-cache invalidation and keeps hit and miss counters for performance measurement.

## Interface
- ADDR_W, 32, word-address width (CPU and memory side)
- INDEX_W, 4, line index bits (2^INDEX_W lines)
- OFFSET_W, 2, word-in-line bits (WORDS = 2^OFFSET_W words per line)
- TAG_W, ADDR_W-INDEX_W-OFFSET_W, derived tag width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- cpu_req  in  1  fetch request, a one-cycle pulse per transaction
- cpu_addr  in  ADDR_W  word address; held stable from acceptance until cpu_valid
- cpu_ready  out  1  request accepted when cpu_req && cpu_ready
- cpu_valid  out  1  one-cycle pulse; cpu_rdata valid
- cpu_rdata  out  32  fetched instruction word
- flush  in  1  invalidate all lines
- mem_req  out  1  backing-memory read request
- mem_addr  out  ADDR_W  backing-memory word address
- mem_valid  in  1  mem_rdata valid for the current mem_addr
- mem_rdata  in  32  backing-memory data
- hit_cnt  out  16  accepted hits, wraps modulo 2^16
- miss_cnt  out  16  accepted misses, wraps modulo 2^16

## Operation
- Address split: offset = addr[OFFSET_W-1:0]; index = addr[OFFSET_W+INDEX_W-1:OFFSET_W]; tag = upper TAG_W bits.
- Storage: per-line valid bit (a vector, so it can be cleared in one cycle), tag register, and WORDS×32 data registers.
- Reset values: state IDLE, all valid bits 0, cpu_valid 0, cpu_rdata 0, mem_req 0, mem_addr 0, refill counter 0, hit_cnt 0, miss_cnt 0, flush_pending 0.
- cpu_ready = (state==IDLE) && !flush && !flush_pending. It is combinational.
- States:
  - IDLE:
    - flush or flush_pending: clear all valid bits and flush_pending; do not accept a request.
    - Else on accepted hit (valid[index] && tag match): register the word into cpu_rdata, pulse cpu_valid next cycle, hit_cnt+1, stay IDLE.
    - Else on accepted miss: latch the request address, miss_cnt+1, set refill counter 0, go to REFILL.
  - REFILL:
    - mem_req=1. mem_addr = {tag, index, counter}, so the refill is line-aligned from word 0.
    - On mem_valid: write mem_rdata to data[index][counter] and increment counter. mem_addr advances in the following cycle.
    - On mem_valid with counter==WORDS-1: set valid[index], write the tag, go to RESP. mem_req drops in the next cycle.
  - RESP: cpu_valid=1 and cpu_rdata = data[index][offset] of the latched address; go to IDLE.
- mem_valid is ignored while mem_req=0. The memory may assert mem_valid in the same cycle as mem_req (zero-wait combinational ROM).
- A flush outside IDLE sets flush_pending. The refill in flight completes, the line is written, and the response is delivered. Invalidation happens in the first following IDLE cycle.
- A flush and a cpu_req in the same cycle: the flush wins and the request is not accepted. The requester re-presents the request when cpu_ready is high.
- A reset at any time, including mid-refill, returns every register to its reset value at that edge. The refill in flight is abandoned, and a partly written line stays invalid.

## Timing
- Hit latency: request accepted at cycle t, cpu_valid at t+1. Back-to-back hits sustain one word per cycle.
- Miss with zero-wait memory: accepted at t; mem_req in t+1..t+WORDS; cpu_valid at t+WORDS+1 (t+5 at defaults); cpu_ready high again at t+WORDS+2.
- Miss with memory latency L (mem_valid L cycles after the address appears): each word takes L+1 cycles, so cpu_valid arrives at t+WORDS·(L+1)+1.
- Counters update on the edge following acceptance.
- cpu_valid and mem_req are registered outputs with no combinational path from inputs. cpu_ready is the only combinational output.

## Test plan
- Cold miss, zero-wait memory with mem[a]=0xA000_0000+a. After reset, request 0x12 -> mem_addr 0x10,0x11,0x12,0x13 in cycles 1–4, cpu_valid in cycle 5 with 0xA000_0012, miss_cnt=1.
- Hit after refill: request 0x13 -> cpu_valid next cycle with 0xA000_0013, no mem_req, hit_cnt=1. Back-to-back requests 0x10, 0x11 -> valid on consecutive cycles.
- Conflict eviction: request 0x110 (same index 4, different tag) -> refill of 0x110–0x113. A following request to 0x10 -> miss again, miss_cnt increments.
- Wait-state memory, L=2: miss on 0x20 -> cpu_valid 13 cycles after acceptance with correct data. mem_addr holds each word until its mem_valid.
- Flush together with cpu_req in IDLE: cpu_ready=0 and the request is not accepted. The next request to 0x12 misses. A flush raised mid-refill: the response is still delivered with correct data, then a repeat request to the same address misses.
- Reset asserted in cycle 2 of a refill: next cycle mem_req=0, cpu_valid=0, counters 0. A request to the same address misses and refills fully.
